mmio_io_bank: RTL

- Parametrised memory-mapped I/O peripheral on the core data bus.
- Replaces the single hard-wired output register at 0x10000.
- Provides N_OUT output channels and N_IN synchronised input channels with change-detect interrupts.
- Adds a free-running cycle counter with a compare interrupt.
- Read data follows the data-BRAM timing (1-cycle latency), so the core's result mux needs no extra stall.

---
 rtl/mmio_io_pkg.sv | 25 ++
 rtl/sync_chain.sv | 25 ++
 rtl/mmio_io_bank.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mmio_io_pkg.sv
// Shared register-map constants and helpers for the MMIO I/O bank.
package mmio_io_pkg;

  localparam logic [7:0] OFF_OUT   = 8'h00;
  localparam logic [7:0] OFF_IN    = 8'h40;
  localparam logic [7:0] OFF_PEND  = 8'h80;
  localparam logic [7:0] OFF_EN    = 8'h84;
  localparam logic [7:0] OFF_CYCLE = 8'h88;
  localparam logic [7:0] OFF_CMP   = 8'h8C;

  localparam int unsigned WINDOW_BYTES = 256;

  function automatic logic [5:0] word_idx(input logic [31:0] addr);
    return addr[7:2];
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for asynchronous inputs, reset to zero.
module sync_chain #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/mmio_io_bank.sv
// Memory-mapped I/O bank: output channels, synchronised inputs with change
// interrupts, free-running cycle counter with compare interrupt.
module mmio_io_bank
  import mmio_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned N_OUT       = 4,
  parameter int unsigned N_IN        = 4,
  parameter int unsigned W           = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [31:0]         addr_i,
  input  logic                we_i,
  input  logic [3:0]          be_i,
  input  logic                re_i,
  input  logic [31:0]         wdata_i,
  output logic                hit_o,
  output logic [31:0]         rdata_o,
  output logic                rvalid_o,
  output logic [N_OUT*W-1:0]  out_o,
  input  logic [N_IN*W-1:0]   in_i,
  output logic                irq_o
);

  localparam int unsigned NP      = N_IN + 1;
  localparam int unsigned WarmCnt = SYNC_STAGES + 1;
  localparam int unsigned WarmW   = $clog2(WarmCnt + 1);

  logic [5:0]         idx;
  logic               wr_en, rd_en, warm_done;
  logic [31:0]        wmask;
  logic [N_IN*W-1:0]  sync_w, prev_q;
  logic [W-1:0]       out_q [N_OUT];
  logic [W-1:0]       out_d [N_OUT];
  logic [NP-1:0]      pend_q, pend_d, en_q, en_d, set_w, clr_w;
  logic [31:0]        cycle_q, cycle_d, cmp_q, cmp_d, rdata_q, rdata_d;
  logic               rvalid_q, irq_q;
  logic [WarmW-1:0]   warm_q;

  // Base is 256-byte aligned, so the window is a match on the upper bits.
  assign hit_o     = (addr_i[31:8] == BASE_ADDR[31:8]);
  assign idx       = word_idx(addr_i);
  assign wr_en     = we_i & hit_o;
  assign rd_en     = re_i & hit_o & ~we_i;
  assign wmask     = be_mask(be_i);
  assign warm_done = (warm_q == WarmW'(WarmCnt));

  sync_chain #(
    .WIDTH  (N_IN * W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (in_i),
    .q_o    (sync_w)
  );

  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      out_d[k] = out_q[k];
      if (wr_en && idx == OFF_OUT[7:2] + 6'(k)) begin
        out_d[k] = (out_q[k] & ~wmask[W-1:0]) | (wdata_i[W-1:0] & wmask[W-1:0]);
      end
    end

    en_d = en_q;
    if (wr_en && idx == OFF_EN[7:2]) begin
      en_d = (en_q & ~wmask[NP-1:0]) | (wdata_i[NP-1:0] & wmask[NP-1:0]);
    end

    cmp_d = cmp_q;
    if (wr_en && idx == OFF_CMP[7:2]) begin
      cmp_d = (cmp_q & ~wmask) | (wdata_i & wmask);
    end

    clr_w = '0;
    if (wr_en && idx == OFF_PEND[7:2]) begin
      clr_w = wdata_i[NP-1:0] & wmask[NP-1:0];
    end

    // Warm-up masks the spurious edge as the chain fills after reset.
    set_w = '0;
    for (int k = 0; k < N_IN; k++) begin
      set_w[k] = warm_done & (|(sync_w[k*W +: W] ^ prev_q[k*W +: W]));
    end
    set_w[N_IN] = (cycle_q == cmp_q);

    pend_d = (pend_q & ~clr_w) | set_w;

    cycle_d = cycle_q + 32'd1;
`ifdef SIM
    if (wr_en && idx == OFF_CYCLE[7:2]) begin
      cycle_d = (cycle_q & ~wmask) | (wdata_i & wmask);
    end
`endif
  end

  always_comb begin
    rdata_d = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (idx == OFF_OUT[7:2] + 6'(k)) rdata_d[W-1:0] = out_q[k];
    end
    for (int k = 0; k < N_IN; k++) begin
      if (idx == OFF_IN[7:2] + 6'(k)) rdata_d[W-1:0] = sync_w[k*W +: W];
    end
    if (idx == OFF_PEND[7:2])  rdata_d[NP-1:0] = pend_q;
    if (idx == OFF_EN[7:2])    rdata_d[NP-1:0] = en_q;
    if (idx == OFF_CYCLE[7:2]) rdata_d         = cycle_q;
    if (idx == OFF_CMP[7:2])   rdata_d         = cmp_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
      prev_q   <= '0;
      pend_q   <= '0;
      en_q     <= '0;
      cycle_q  <= '0;
      cmp_q    <= 32'hFFFF_FFFF;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
      warm_q   <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= out_d[k];
      prev_q   <= sync_w;
      pend_q   <= pend_d;
      en_q     <= en_d;
      cycle_q  <= cycle_d;
      cmp_q    <= cmp_d;
      rvalid_q <= rd_en;
      if (rd_en) rdata_q <= rdata_d;
      irq_q    <= |(pend_q & en_q);
      if (!warm_done) warm_q <= warm_q + WarmW'(1);
    end
  end

  always_comb begin
    out_o = '0;
    for (int k = 0; k < N_OUT; k++) out_o[k*W +: W] = out_q[k];
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign irq_o    = irq_q;

endmodule
